// File: rtl/systolic_pkg.sv
// Shared defaults and encodings for the systolic array datapath.
// Used by the skew buffer and its interface.
package systolic_pkg;

  localparam int BITS_AB = 8;
  localparam int DIM_AB  = 8;

  typedef logic signed [DIM_AB-1:0][BITS_AB-1:0] lane_row_t;

  localparam logic MODE_SKEW   = 1'b0;
  localparam logic MODE_DESKEW = 1'b1;

endpackage

// File: rtl/mem_skew_buf_if.sv
// Row bus between the array feeder and the skew buffer.
// Master drives rows and mode requests; slave returns lanes.
interface mem_skew_buf_if
  import systolic_pkg::*;
#(
  parameter int BITS = BITS_AB,
  parameter int DIM  = DIM_AB
);

  logic                           en;
  logic                           mode_req;
  logic                           in_valid;
  logic                           in_last;
  logic signed [DIM-1:0][BITS-1:0] din;
  logic signed [DIM-1:0][BITS-1:0] dout;
  logic [DIM-1:0]                 out_valid;
  logic                           tile_done;
  logic                           mode;
  logic                           idle;

  modport master (
    output en, mode_req, in_valid, in_last, din,
    input  dout, out_valid, tile_done, mode, idle
  );

  modport slave (
    input  en, mode_req, in_valid, in_last, din,
    output dout, out_valid, tile_done, mode, idle
  );

endinterface

// File: rtl/mem_skew_buf_skew_lane.sv
// One lane of the skew buffer: a shift line with a run-time tap.
// Tap 0 is the input register itself, tap k is k stages later.
module skew_lane #(
  parameter int W     = 9,
  parameter int DEPTH = 7,
  parameter int DLY_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [W-1:0]     d_i,
  input  logic [DLY_W-1:0] sel_i,
  output logic [W-1:0]     q_o,
  output logic             busy_o
);

  logic [DEPTH-1:0][W-1:0] sr_q;
  logic [DEPTH-1:0][W-1:0] sr_d;
  logic [DEPTH:0][W-1:0]   tap;

  // next state: every stage takes its predecessor
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = d_i;
    for (int k = 1; k < DEPTH; k++) begin
      sr_d[k] = sr_q[k-1];
    end
  end

  // shift only on enabled edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q <= sr_d;
    end
  end

  // tap select plus valid scan across all stages
  always_comb begin
    tap    = '0;
    tap[0] = d_i;
    busy_o = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tap[k+1] = sr_q[k];
      busy_o   = busy_o | sr_q[k][W-1];
    end
    q_o = tap[sel_i];
  end

endmodule

// File: rtl/mem_skew_buf.sv
// Operand skew / result deskew buffer for the systolic array.
// Input register, DIM lanes, tile-end line, idle and mode logic.
module mem_skew_buf
  import systolic_pkg::*;
#(
  parameter int BITS = BITS_AB,
  parameter int DIM  = DIM_AB
) (
  input logic           clk,
  input logic           rst,
  mem_skew_buf_if.slave bus
);

  localparam int DLY_W = $clog2(DIM);

  logic                     in_v_q, in_v_d;
  logic [DIM-1:0][BITS-1:0] in_d_q, in_d_d;
  logic [DIM-1:0]           last_q, last_d;
  logic                     mode_q, mode_d;
  logic [DIM-1:0]           busy;
  logic [DIM-1:0][BITS-1:0] dout_w;
  logic [DIM-1:0]           ov_w;
  logic                     idle;

  // input capture with zero fill on idle cycles
  always_comb begin
    in_v_d = bus.in_valid;
    in_d_d = bus.in_valid ? bus.din : '0;
  end

  // tile-end marker runs as long as the slowest lane
  always_comb begin
    last_d = {last_q[DIM-2:0], bus.in_valid & bus.in_last};
  end

  // idle is taken from registered state only
  always_comb begin
    idle = ~in_v_q & ~(|busy) & ~(|last_q);
  end

  // a mode change is only safe with the buffer drained
  always_comb begin
    mode_d = mode_q;
    if (idle && !bus.in_valid && (bus.mode_req != mode_q)) begin
      mode_d = bus.mode_req;
    end
  end

  // all top-level state advances on enabled edges only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_v_q <= 1'b0;
      in_d_q <= '0;
      last_q <= '0;
      mode_q <= MODE_SKEW;
    end else if (bus.en) begin
      in_v_q <= in_v_d;
      in_d_q <= in_d_d;
      last_q <= last_d;
      mode_q <= mode_d;
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    localparam logic [DLY_W-1:0] SK = DLY_W'(i);
    localparam logic [DLY_W-1:0] DS = DLY_W'(DIM - 1 - i);
    logic [DLY_W-1:0] sel;
    logic [BITS:0]    lq;

    assign sel = (mode_q == MODE_DESKEW) ? DS : SK;

    skew_lane #(
      .W     (BITS + 1),
      .DEPTH (DIM - 1),
      .DLY_W (DLY_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (bus.en),
      .d_i    ({in_v_q, in_d_q[i]}),
      .sel_i  (sel),
      .q_o    (lq),
      .busy_o (busy[i])
    );

    assign ov_w[i]   = lq[BITS];
    assign dout_w[i] = lq[BITS-1:0];
  end

  assign bus.dout      = dout_w;
  assign bus.out_valid = ov_w;
  assign bus.tile_done = last_q[DIM-1];
  assign bus.mode      = mode_q;
  assign bus.idle      = idle;

endmodule

// File: tb/tb_mem_skew_buf.sv
// Scoreboard bench for mem_skew_buf, DIM=4, BITS=8.
// Driver pushes expected lane events; monitor pops and compares.
module tb_mem_skew_buf;
  import systolic_pkg::*;

  localparam int DIM  = 4;
  localparam int BITS = 8;

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_skew_buf_if #(.BITS(BITS), .DIM(DIM)) bus ();

  mem_skew_buf #(.BITS(BITS), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t lq [DIM][$];
  int   tq [$];
  int   ecyc;
  int   last_e;
  logic mode_m;
  logic exp_idle;
  bit   stepped;
  int   total;
  int   bad;
  logic [DIM-1:0][7:0] hd;
  logic [DIM-1:0]      hv;
  logic                ht;

  function automatic int dly(int i, logic m);
    return m ? (DIM - 1 - i) : i;
  endfunction

  function automatic logic [DIM-1:0][7:0] mkrow(int base);
    logic [DIM-1:0][7:0] r;
    for (int i = 0; i < DIM; i++) r[i] = 8'(base + i);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, req);
    end
  endtask

  // one clock of stimulus; model advances for the coming edge
  task automatic cyc(bit e, bit v, bit l, logic [DIM-1:0][7:0] r, bit req);
    @(negedge clk);
    #1;
    bus.en       = e;
    bus.in_valid = v;
    bus.in_last  = l;
    bus.din      = r;
    bus.mode_req = req;
    stepped      = e;
    if (e) begin
      if ((ecyc > last_e + DIM - 1) && !v && (logic'(req) != mode_m))
        mode_m = req;
      ecyc++;
      if (v) begin
        last_e = ecyc;
        for (int i = 0; i < DIM; i++) begin
          exp_t x;
          x.due = ecyc + dly(i, mode_m);
          x.val = r[i];
          lq[i].push_back(x);
        end
        if (l) tq.push_back(ecyc + DIM - 1);
      end
      exp_idle = (ecyc > last_e + DIM - 1);
    end
  endtask

  task automatic gap(int n, bit req);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, '0, req);
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_dout"}, bus.dout, 32'd0);
    chk({nm, "_ov"},   {28'd0, bus.out_valid}, 32'd0);
    chk({nm, "_td"},   {31'd0, bus.tile_done}, 32'd0);
    chk({nm, "_mode"}, {31'd0, bus.mode}, 32'd0);
    chk({nm, "_idle"}, {31'd0, bus.idle}, 32'd1);
  endtask

  // monitor: compare every sample against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hv = '0;
        hd = '0;
        ht = 1'b0;
      end else begin
        if (stepped) begin
          for (int i = 0; i < DIM; i++) begin
            while (lq[i].size() > 0 && lq[i][0].due < ecyc) begin
              chk($sformatf("late%0d", i), lq[i][0].due, ecyc);
              void'(lq[i].pop_front());
            end
            if (lq[i].size() > 0 && lq[i][0].due == ecyc) begin
              hv[i] = 1'b1;
              hd[i] = lq[i][0].val;
              void'(lq[i].pop_front());
            end else begin
              hv[i] = 1'b0;
              hd[i] = 8'd0;
            end
          end
          while (tq.size() > 0 && tq[0] < ecyc) begin
            chk("td_late", tq[0], ecyc);
            void'(tq.pop_front());
          end
          if (tq.size() > 0 && tq[0] == ecyc) begin
            ht = 1'b1;
            void'(tq.pop_front());
          end else begin
            ht = 1'b0;
          end
        end
        for (int i = 0; i < DIM; i++) begin
          chk($sformatf("lane%0d", i),
              {23'd0, bus.out_valid[i], bus.dout[i]},
              {23'd0, hv[i], hd[i]});
        end
        chk("tile_done", {31'd0, bus.tile_done}, {31'd0, ht});
        chk("idle", {31'd0, bus.idle}, {31'd0, exp_idle});
        chk("mode", {31'd0, bus.mode}, {31'd0, mode_m});
      end
    end
  end

  initial begin
    bit req_r;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.din      = '0;
    bus.mode_req = 1'b0;
    stepped      = 1'b0;
    ecyc         = 0;
    last_e       = -100;
    mode_m       = MODE_SKEW;
    exp_idle     = 1'b1;
    total        = 0;
    bad          = 0;
    #2;
    chk_reset("por");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // single skew row, lane0 = 1
    cyc(1'b1, 1'b1, 1'b1, mkrow(1), 1'b0);
    gap(6, 1'b0);

    // switch to deskew, same row
    gap(2, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, mkrow(1), 1'b1);
    gap(6, 1'b1);
    gap(2, 1'b0);

    // two back-to-back tiles with an enable stall
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, (k % 4) == 3, mkrow(16 * k), 1'b0);
      if (k == 5) begin
        for (int s = 0; s < 3; s++)
          cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
      end
    end
    gap(8, 1'b0);

    // mode request raised with data in flight
    cyc(1'b1, 1'b1, 1'b0, mkrow(8'h40), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, mkrow(8'h50), 1'b0);
    gap(8, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, mkrow(8'h60), 1'b1);
    gap(6, 1'b1);
    gap(2, 1'b0);

    // asynchronous reset with three rows in flight
    cyc(1'b1, 1'b1, 1'b0, mkrow(8'h70), 1'b0);
    cyc(1'b1, 1'b1, 1'b0, mkrow(8'h80), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, mkrow(8'h90), 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    for (int i = 0; i < DIM; i++) lq[i].delete();
    tq.delete();
    ecyc         = 0;
    last_e       = -100;
    mode_m       = MODE_SKEW;
    exp_idle     = 1'b1;
    stepped      = 1'b0;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.mode_req = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    gap(8, 1'b0);

    // random traffic, stalls and mode requests
    req_r = 1'b0;
    for (int k = 0; k < 400; k++) begin
      logic [DIM-1:0][7:0] r;
      for (int i = 0; i < DIM; i++) r[i] = 8'($urandom);
      if ($urandom_range(0, 40) == 0) req_r = ~req_r;
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) == 0, r, req_r);
    end
    gap(10, req_r);
    gap(10, req_r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
